// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter that shares one single-port synchronous RAM
//   between requester 0 (pipeline MEM stage) and requester 1 (debug/loader port).
// Latency: req sampled in IDLE at edge N -> ack high in the cycle after edge N+1;
//   every transaction walks IDLE -> ACCESS -> RESP, so at most one per 3 cycles.
// Backpressure: requesters hold req as a level until their one-cycle ack; req and
//   command inputs are only looked at in IDLE, so a busy arbiter simply stalls them.
//
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-high reset
//   mX_req/rw/sel/addr/wdata requester X command (rw: 1 = write, 0 = read)
//   mX_ack, mX_rdata         requester X one-cycle completion strobe and read data
//   ram_rw/sel/addr/data_in  command to the RAM, stable through ACCESS
//   ram_data_out             RAM registered read data (updated on the falling edge)
//   busy                     high in ACCESS and RESP
//   grant_id                 owner of the current or most recent transaction
//   m0_count, m1_count       saturating completed-transaction counters

module ram_port_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             m0_req,
  input  logic             m0_rw,
  input  logic [3:0]       m0_sel,
  input  logic [9:0]       m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_ack,
  output logic [31:0]      m0_rdata,

  input  logic             m1_req,
  input  logic             m1_rw,
  input  logic [3:0]       m1_sel,
  input  logic [9:0]       m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_ack,
  output logic [31:0]      m1_rdata,

  output logic             ram_rw,
  output logic [3:0]       ram_sel,
  output logic [9:0]       ram_addr,
  output logic [31:0]      ram_data_in,
  input  logic [31:0]      ram_data_out,

  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] m0_count,
  output logic [CNT_W-1:0] m1_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t       state;
  state_t       state_nxt;
  logic         load_cmd;

  logic         win_id;
  logic         any_req;

  logic         cmd_rw;
  logic [3:0]   cmd_sel;
  logic [9:0]   cmd_addr;
  logic [31:0]  cmd_wdata;

  logic         in_access;
  logic         in_resp;

  // ------------------------------------------------------------------
  // Arbitration. On a tie the requester that did NOT own the last
  // transaction wins; grant_id resets to 1 so requester 0 takes the
  // first tie after reset.
  // ------------------------------------------------------------------
  assign any_req = m0_req | m1_req;

  always_comb begin
    win_id = 1'b0;
    if (m0_req && m1_req) begin
      win_id = ~grant_id;
    end else if (m1_req) begin
      win_id = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_cmd  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
          load_cmd  = 1'b1;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP);

  // ------------------------------------------------------------------
  // Command capture. The winner's command is frozen on the IDLE->ACCESS
  // edge, so requesters are free to change their inputs afterwards.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id  <= 1'b1;
      cmd_rw    <= 1'b0;
      cmd_sel   <= 4'b0000;
      cmd_addr  <= 10'd0;
      cmd_wdata <= 32'd0;
    end else if (load_cmd) begin
      grant_id  <= win_id;
      cmd_rw    <= win_id ? m1_rw    : m0_rw;
      cmd_sel   <= win_id ? m1_sel   : m0_sel;
      cmd_addr  <= win_id ? m1_addr  : m0_addr;
      cmd_wdata <= win_id ? m1_wdata : m0_wdata;
    end
  end

  // ------------------------------------------------------------------
  // RAM side. The RAM samples on the falling edge, so the command is
  // held for all of ACCESS and is fully settled by mid-cycle. Write
  // enable and lane select are forced low elsewhere so the RAM never
  // sees a stray access; address/data just keep their last value.
  // Lane select goes through untouched, whatever the pattern.
  // ------------------------------------------------------------------
  assign ram_rw      = in_access & cmd_rw;
  assign ram_sel     = in_access ? cmd_sel : 4'b0000;
  assign ram_addr    = cmd_addr;
  assign ram_data_in = cmd_wdata;

  // ------------------------------------------------------------------
  // Requester side. The RAM's registered data (updated during ACCESS)
  // is stable throughout RESP, so it is steered straight through.
  // ------------------------------------------------------------------
  assign busy   = in_access | in_resp;
  assign m0_ack = in_resp & ~grant_id;
  assign m1_ack = in_resp &  grant_id;

  assign m0_rdata = (m0_ack && !cmd_rw) ? ram_data_out : 32'd0;
  assign m1_rdata = (m1_ack && !cmd_rw) ? ram_data_out : 32'd0;

  // ------------------------------------------------------------------
  // Completed-transaction counters, saturating at all-ones. They bump
  // on the edge that ends RESP, so an aborted (reset) transaction is
  // never counted.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_count <= '0;
    end else if (m0_ack && (m0_count != CNT_MAX)) begin
      m0_count <= m0_count + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_count <= '0;
    end else if (m1_ack && (m1_count != CNT_MAX)) begin
      m1_count <= m1_count + CNT_ONE;
    end
  end

  // ------------------------------------------------------------------
  // Structural invariants
  // ------------------------------------------------------------------
  a_ack_onehot: assert property (@(posedge clk) disable iff (rst)
    !(m0_ack && m1_ack));

  a_ram_quiet: assert property (@(posedge clk) disable iff (rst)
    !in_access |-> (!ram_rw && (ram_sel == 4'b0000)));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus for ram_port_arbiter with a scoreboard.
// A behavioural RAM answers on the falling edge; a second instance with CNT_W=2
// runs in lockstep to exercise counter saturation.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [3:0]  m0_sel, m1_sel;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;

  logic        m0_ack, m1_ack, busy, grant_id, ram_rw;
  logic [31:0] m0_rdata, m1_rdata, ram_data_in;
  logic [3:0]  ram_sel;
  logic [9:0]  ram_addr;
  logic [15:0] m0_count, m1_count;
  logic [31:0] ram_data_out = 32'd0;

  logic        b_m0_ack, b_m1_ack, b_busy, b_grant_id, b_ram_rw;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_ram_data_in;
  logic [3:0]  b_ram_sel;
  logic [9:0]  b_ram_addr;
  logic [1:0]  b_m0_count, b_m1_count;

  ram_port_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_rw(ram_rw), .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out),
    .busy(busy), .grant_id(grant_id), .m0_count(m0_count), .m1_count(m1_count)
  );

  ram_port_arbiter #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .ram_rw(b_ram_rw), .ram_sel(b_ram_sel), .ram_addr(b_ram_addr), .ram_data_in(b_ram_data_in),
    .ram_data_out(ram_data_out),
    .busy(b_busy), .grant_id(b_grant_id), .m0_count(b_m0_count), .m1_count(b_m1_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: falling-edge sampling, byte-lane writes; reads return the
  // selected lanes packed toward bit 0 (a single lane lands in the low byte).
  logic [31:0] mem [0:1023];
  logic [31:0] rd_tmp;
  int          rd_k;
  always @(negedge clk) begin
    if (ram_sel != 4'b0000) begin
      if (ram_rw) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel[b]) mem[ram_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
      end else begin
        rd_tmp = 32'd0;
        rd_k   = 0;
        for (int b = 0; b < 4; b++)
          if (ram_sel[b]) begin
            rd_tmp[8*rd_k +: 8] = mem[ram_addr][8*b +: 8];
            rd_k++;
          end
        ram_data_out <= rd_tmp;
      end
    end
  end

  typedef struct {
    logic        id;
    logic        rw;
    logic [3:0]  sel;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] mcnt  [2];
  logic [1:0]  mcnt2 [2];
  bit          chk_ram = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic id, input logic rw, input logic [3:0] sel,
                          input logic [9:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_cyc);
    exp_t e;
    mcnt[id]  = mcnt[id] + 16'd1;
    mcnt2[id] = (mcnt2[id] == 2'd3) ? 2'd3 : mcnt2[id] + 2'd1;
    e.id = id; e.rw = rw; e.sel = sel; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.ack_cyc = ack_cyc; e.cnt = mcnt[id]; e.cnt2 = mcnt2[id];
    sb_q.push_back(e);
  endtask

  // Monitor: command on the RAM port, ack timing/ownership, read data, counters.
  logic prev_ack = 1'b0;
  bit   cnt_pend = 1'b0;
  exp_t pend;
  always @(negedge clk) begin
    exp_t e;
    if (cnt_pend) begin
      cnt_pend = 1'b0;
      check("count", pend.id ? m1_count : m0_count, pend.cnt);
      check("count_w2", pend.id ? b_m1_count : b_m0_count, pend.cnt2);
    end
    if (chk_ram && !rst) begin
      if (sb_q.size() > 0 && cyc == sb_q[0].ack_cyc - 1) begin
        check("access_cmd", {ram_rw, ram_sel, ram_addr, ram_data_in},
              {sb_q[0].rw, sb_q[0].sel, sb_q[0].addr, sb_q[0].wdata});
        check("busy_access", busy, 1'b1);
      end else begin
        check("ram_quiet", {ram_rw, ram_sel}, 5'h00);
      end
    end
    if (!m0_ack) check("m0_rdata_zero", m0_rdata, 32'd0);
    if (!m1_ack) check("m1_rdata_zero", m1_rdata, 32'd0);
    if (m0_ack || m1_ack) begin
      check("ack_exclusive", m0_ack & m1_ack, 1'b0);
      check("ack_one_cycle", prev_ack, 1'b0);
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b expected none (t=%0t)",
                 m0_ack, m1_ack, $time);
      end else begin
        e = sb_q.pop_front();
        check("ack_id", m1_ack, e.id);
        check("grant_id", grant_id, e.id);
        check("ack_cycle", cyc, e.ack_cyc);
        check("rdata", e.id ? m1_rdata : m0_rdata, e.rdata);
        pend     = e;
        cnt_pend = 1'b1;
      end
    end
    prev_ack = m0_ack | m1_ack;
  end

  // Issue one transaction with the arbiter idle; called #1 after a rising edge.
  // The command inputs are inverted once captured, which must not matter.
  task automatic do_txn(input logic id, input logic rw, input logic [3:0] sel,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata);
    bit got = 1'b0;
    if (id) begin
      m1_rw = rw; m1_sel = sel; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end else begin
      m0_rw = rw; m0_sel = sel; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end
    push_exp(id, rw, sel, addr, wdata, exp_rdata, cyc + 2);
    @(posedge clk); #1;
    if (id) begin
      m1_rw = ~rw; m1_sel = ~sel; m1_addr = ~addr; m1_wdata = ~wdata;
    end else begin
      m0_rw = ~rw; m0_sel = ~sel; m0_addr = ~addr; m0_wdata = ~wdata;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (id ? m1_ack : m0_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: got no m%0d_ack expected one within 10 cycles", id);
    end
    @(posedge clk); #1;
    if (id) m1_req = 1'b0;
    else    m0_req = 1'b0;
  endtask

  task automatic apply_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_ram = 1'b0;
    mcnt[0] = '0; mcnt[1] = '0; mcnt2[0] = '0; mcnt2[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_ram = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1);
  end

  initial begin
    int c;
    int acks;
    rst = 1'b1;
    m0_req = 0; m0_rw = 0; m0_sel = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_rw = 0; m1_sel = 0; m1_addr = 0; m1_wdata = 0;
    mcnt[0] = '0; mcnt[1] = '0; mcnt2[0] = '0; mcnt2[1] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, 1'b1);
    check("rst_acks", {m0_ack, m1_ack}, 2'b00);
    check("rst_counts", {m0_count, m1_count, b_m0_count, b_m1_count}, 36'd0);
    check("rst_ram_cmd", {ram_rw, ram_sel, ram_addr, ram_data_in}, 47'd0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_ram = 1'b1;

    // m0 write then read back the same word
    do_txn(1'b0, 1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 32'd0);
    do_txn(1'b0, 1'b0, 4'hF, 10'h005, 32'd0, 32'hDEADBEEF);

    // Both requesters held from reset: grants alternate m0, m1, m0, m1
    apply_reset();
    m0_rw = 1'b1; m0_sel = 4'hF; m0_addr = 10'd20; m0_wdata = 32'hA5A50001;
    m1_rw = 1'b0; m1_sel = 4'hF; m1_addr = 10'h005; m1_wdata = 32'd0;
    m0_req = 1'b1; m1_req = 1'b1;
    c = cyc;
    push_exp(1'b0, 1'b1, 4'hF, 10'd20, 32'hA5A50001, 32'd0,        c + 2);
    push_exp(1'b1, 1'b0, 4'hF, 10'h005, 32'd0,       32'hDEADBEEF, c + 5);
    push_exp(1'b0, 1'b1, 4'hF, 10'd20, 32'hA5A50001, 32'd0,        c + 8);
    push_exp(1'b1, 1'b0, 4'hF, 10'h005, 32'd0,       32'hDEADBEEF, c + 11);
    acks = 0;
    for (int i = 0; i < 20 && acks < 4; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) acks++;
    end
    check("rr_ack_total", acks, 4);
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;

    // m1 full-word write, then single-lane read of lane 1
    do_txn(1'b1, 1'b1, 4'hF,    10'h007, 32'h11223344, 32'd0);
    do_txn(1'b1, 1'b0, 4'b0010, 10'h007, 32'd0,        32'h00000033);

    // Reset in the middle of an m0 write: abort, no ack
    m0_rw = 1'b1; m0_sel = 4'hF; m0_addr = 10'h009; m0_wdata = 32'h12345678;
    m0_req = 1'b1;
    chk_ram = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_pre_rw", ram_rw, 1'b1);
    check("abort_pre_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_ram_rw", ram_rw, 1'b0);
    check("abort_ram_sel", ram_sel, 4'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_counts", {m0_count, m1_count}, 32'd0);
    check("abort_ack", m0_ack, 1'b0);
    m0_req = 1'b0;
    mcnt[0] = '0; mcnt[1] = '0; mcnt2[0] = '0; mcnt2[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_ram = 1'b1;

    // Fresh arbitration after the abort
    do_txn(1'b0, 1'b0, 4'hF, 10'h005, 32'd0, 32'hDEADBEEF);

    // Five m1 transactions: the 2-bit counter reads 1,2,3,3,3
    for (int i = 0; i < 5; i++)
      do_txn(1'b1, 1'b1, 4'hF, 10'(30 + i), 32'(i), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
